// File: rtl/snn_output_pkg.sv
// Shared types and helpers for the output spike counter slice.
//
// Contents:
//   scan_state_t  - argmax scanner states (IDLE, SCAN, DONE)
//   idx_width()   - index width for a table of n entries (never below 1)
//   count_max()   - saturation value of a w-bit counter, 2^w-1
//
// Feature macro used by the slice: OUTPUT_SPIKE_ARGMAX_EN
package snn_output_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/output_spike_counter_argmax_scanner.sv
// argmax_scanner: sequential argmax over the result bank, one entry per cycle.
//
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   start          - bank has just been loaded; begin a scan
//   scan_val       - bank entry at scan_idx (muxed by the parent)
//   scan_idx       - bank index currently being visited
//   busy           - scanner is not idle (SCAN or DONE)
//   last           - final index is being visited this cycle
//   class_out      - index of the largest entry (lowest index on ties)
//   class_valid    - one-cycle pulse while in DONE
//
// Only built when OUTPUT_SPIKE_ARGMAX_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a bank load
// SCAN    | visiting index scan_idx, tracking best_val/idx
// DONE    | class_out/class_valid presented for one cycle
module argmax_scanner
    import snn_output_pkg::*;
#(
    parameter int NUM_OUTPUTS = 256,
    parameter int COUNT_WIDTH = 8,
    localparam int IDX_W = idx_width(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] scan_val,
    output logic [IDX_W-1:0]       scan_idx,
    output logic                   busy,
    output logic                   last,
    output logic [IDX_W-1:0]       class_out,
    output logic                   class_valid
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

    scan_state_t            state;
    logic [IDX_W-1:0]       idx;
    logic [COUNT_WIDTH-1:0] best_val;
    logic [IDX_W-1:0]       best_idx;
    logic                   take;

    assign scan_idx = idx;
    assign busy     = (state != ST_IDLE);
    assign last     = (state == ST_SCAN) && (idx == IDX_LAST);
    // Strictly greater keeps the earliest index on ties.
    assign take     = (scan_val > best_val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            class_out   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SCAN;
                        idx      <= '0;
                        best_val <= '0;
                        best_idx <= '0;
                    end
                end
                ST_SCAN: begin
                    if (take) begin
                        best_val <= scan_val;
                        best_idx <= idx;
                    end
                    if (idx == IDX_LAST) begin
                        // Fold the final entry in directly so DONE shows the result.
                        state       <= ST_DONE;
                        class_out   <= take ? idx : best_idx;
                        class_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/output_spike_counter.sv
// output_spike_counter: per-neuron spike accumulation over a frame of
// FRAME_TICKS ticks, with the totals latched into a host-readable bank.
//
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   tick                - end-of-network-tick pulse
//   packet_in(_valid)   - output-neuron index from the output bus
//   result_ack          - host consumed the bank; clears result_valid
//   clear_errors        - clears frame_overrun and count_saturated
//   rd_en, rd_addr      - bank read request
//   rd_data, rd_valid   - registered read response, one cycle later
//   result_valid        - bank holds an unacknowledged frame
//   class_out           - argmax of the last frame
//   class_valid         - pulse when class_out updates
//   frame_overrun       - sticky: a frame was dropped (bank busy)
//   count_saturated     - sticky: an increment hit a saturated counter
//
// Macro OUTPUT_SPIKE_ARGMAX_EN adds the argmax scanner; result_valid then
// rises when the scan completes instead of right after the bank load.
module output_spike_counter
    import snn_output_pkg::*;
#(
    parameter int NUM_OUTPUTS = 256,
    parameter int COUNT_WIDTH = 8,
    parameter int FRAME_TICKS = 16,
    localparam int IDX_W = idx_width(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic [IDX_W-1:0]       packet_in,
    input  logic                   packet_in_valid,
    input  logic                   result_ack,
    input  logic                   clear_errors,
    input  logic                   rd_en,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [COUNT_WIDTH-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       class_out,
    output logic                   class_valid,
    output logic                   frame_overrun,
    output logic                   count_saturated
);

    localparam int TICK_W = idx_width(FRAME_TICKS);
    localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(FRAME_TICKS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));

    logic [COUNT_WIDTH-1:0] acc      [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0] acc_next [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0] bank     [NUM_OUTPUTS];
    logic [TICK_W-1:0]      tick_cnt;
    logic                   frame_end;
    logic                   bank_free;
    logic                   bank_load;
    logic                   sat_hit;
    logic                   scan_busy;

    // acc_next already contains this cycle's packet, so a packet in the
    // frame-end cycle lands in the closing frame's bank.
    always_comb begin
        sat_hit = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            acc_next[i] = acc[i];
            if (packet_in_valid && (packet_in == IDX_W'(i))) begin
                if (acc[i] == COUNT_MAX) begin
                    sat_hit = 1'b1;
                end else begin
                    acc_next[i] = acc[i] + 1'b1;
                end
            end
        end
    end

    assign frame_end = tick && (tick_cnt == TICK_LAST);
    assign bank_free = (!result_valid || result_ack) && !scan_busy;
    assign bank_load = frame_end && bank_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                acc[i]  <= '0;
                bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                acc[i] <= frame_end ? '0 : acc_next[i];
                if (bank_load) begin
                    bank[i] <= acc_next[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= frame_end ? '0 : tick_cnt + 1'b1;
        end
    end

    // Clear first so a set event in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_overrun   <= 1'b0;
            count_saturated <= 1'b0;
        end else begin
            if (clear_errors) begin
                frame_overrun   <= 1'b0;
                count_saturated <= 1'b0;
            end
            if (sat_hit) begin
                count_saturated <= 1'b1;
            end
            if (frame_end && !bank_free) begin
                frame_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= bank[rd_addr];
            end
        end
    end

`ifdef OUTPUT_SPIKE_ARGMAX_EN
    logic [IDX_W-1:0]       scan_idx;
    logic [COUNT_WIDTH-1:0] scan_val;
    logic                   scan_last;

    assign scan_val = bank[scan_idx];

    argmax_scanner #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_scanner (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (bank_load),
        .scan_val    (scan_val),
        .scan_idx    (scan_idx),
        .busy        (scan_busy),
        .last        (scan_last),
        .class_out   (class_out),
        .class_valid (class_valid)
    );

    // result_valid is 0 throughout a scan, so completion and ack never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
        end else if (scan_last) begin
            result_valid <= 1'b1;
        end else if (result_ack) begin
            result_valid <= 1'b0;
        end
    end
`else
    assign scan_busy   = 1'b0;
    assign class_out   = '0;
    assign class_valid = 1'b0;

    // A load in the same cycle as an ack re-asserts result_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
        end else if (bank_load) begin
            result_valid <= 1'b1;
        end else if (result_ack) begin
            result_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_output_spike_counter.sv
// Self-checking bench for output_spike_counter (NUM_OUTPUTS=8, COUNT_WIDTH=4,
// FRAME_TICKS=4). Works with or without OUTPUT_SPIKE_ARGMAX_EN defined.
module tb_output_spike_counter;

    localparam int N   = 8;
    localparam int CW  = 4;
    localparam int FT  = 4;
    localparam int IW  = 3;
    localparam int MAX = 15;

    logic          clk;
    logic          reset_n;
    logic          tick;
    logic [IW-1:0] packet_in;
    logic          packet_in_valid;
    logic          result_ack;
    logic          clear_errors;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic [CW-1:0] rd_data;
    logic          rd_valid;
    logic          result_valid;
    logic [IW-1:0] class_out;
    logic          class_valid;
    logic          frame_overrun;
    logic          count_saturated;

    output_spike_counter #(
        .NUM_OUTPUTS (N),
        .COUNT_WIDTH (CW),
        .FRAME_TICKS (FT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tick            (tick),
        .packet_in       (packet_in),
        .packet_in_valid (packet_in_valid),
        .result_ack      (result_ack),
        .clear_errors    (clear_errors),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .result_valid    (result_valid),
        .class_out       (class_out),
        .class_valid     (class_valid),
        .frame_overrun   (frame_overrun),
        .count_saturated (count_saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_acc [N];
    int m_bank [N];
    int m_tc, m_cnt, m_exp, m_class, m_rdd;
    bit m_rv, m_cv, m_over, m_sat, m_rdv;

    function automatic int first_max();
        int b = 0;
        for (int i = 1; i < N; i++) if (m_bank[i] > m_bank[b]) b = i;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i]  = 0;
            m_bank[i] = 0;
        end
        m_tc = 0; m_cnt = 0; m_exp = 0; m_class = 0; m_rdd = 0;
        m_rv = 0; m_cv = 0; m_over = 0; m_sat = 0; m_rdv = 0;
    endtask

    task automatic model_step();
        bit fe, fr;
        fe = tick && (m_tc == FT - 1);
        fr = (!m_rv || result_ack) && (m_cnt == 0);
        if (rd_en) m_rdd = m_bank[rd_addr];
        m_rdv = rd_en;
        if (clear_errors) begin
            m_over = 0;
            m_sat  = 0;
        end
        if (packet_in_valid) begin
            if (m_acc[packet_in] == MAX) m_sat = 1;
            else m_acc[packet_in]++;
        end
        if (result_ack) m_rv = 0;
        m_cv = 0;
        // m_cnt counts remaining cycles of scan+done; 1 means "in DONE".
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 1) begin
                m_cv    = 1;
                m_rv    = 1;
                m_class = m_exp;
            end
        end
        if (fe) begin
            if (fr) begin
                for (int i = 0; i < N; i++) m_bank[i] = m_acc[i];
`ifdef OUTPUT_SPIKE_ARGMAX_EN
                m_cnt = N + 1;
                m_exp = first_max();
`else
                m_rv = 1;
`endif
            end else begin
                m_over = 1;
            end
            for (int i = 0; i < N; i++) m_acc[i] = 0;
        end
        if (tick) m_tc = fe ? 0 : m_tc + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && chk_en) begin
                check("cmp_result_valid", result_valid, m_rv);
                check("cmp_class_valid", class_valid, m_cv);
                check("cmp_class_out", class_out, m_class);
                check("cmp_frame_overrun", frame_overrun, m_over);
                check("cmp_count_saturated", count_saturated, m_sat);
                check("cmp_rd_valid", rd_valid, m_rdv);
                if (m_rdv) check("cmp_rd_data", rd_data, m_rdd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit t, input bit pv, input int pidx, input bit ack,
                         input bit clr, input bit re, input int ra);
        tick            = t;
        packet_in_valid = pv;
        packet_in       = IW'(pidx);
        result_ack      = ack;
        clear_errors    = clr;
        rd_en           = re;
        rd_addr         = IW'(ra);
        @(posedge clk);
        #2;
        tick            = 1'b0;
        packet_in_valid = 1'b0;
        result_ack      = 1'b0;
        clear_errors    = 1'b0;
        rd_en           = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int idx, input int count);
        repeat (count) drive(0, 1, idx, 0, 0, 0, 0);
    endtask

    task automatic close_frame(input bit ack_at_end);
        repeat (FT - 1) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, ack_at_end, 0, 0, 0);
    endtask

    task automatic wait_result();
        for (int k = 0; k < 40; k++) begin
            if (m_rv && m_cnt == 0) return;
            idle(1);
        end
        check("wait_result_timeout", 1, 0);
    endtask

    task automatic read_chk(input int addr, input int exp, input string name);
        drive(0, 0, 0, 0, 0, 1, addr);
        check(name, rd_data, exp);
    endtask

    task automatic ack();
        drive(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_class_out"}, class_out, 0);
        check({tag, "_class_valid"}, class_valid, 0);
        check({tag, "_frame_overrun"}, frame_overrun, 0);
        check({tag, "_count_saturated"}, count_saturated, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k, seen;
        reset_n = 1'b0;
        tick = 0; packet_in = '0; packet_in_valid = 0; result_ack = 0;
        clear_errors = 0; rd_en = 0; rd_addr = '0;
        #23;
        check_all_zero("reset");
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(posedge clk);
        #2;

        // Basic frame
        send(2, 3);
        send(6, 5);
        send(0, 1);
        close_frame(0);
`ifdef OUTPUT_SPIKE_ARGMAX_EN
        k = 1;
        while (k <= 20 && !class_valid) begin
            idle(1);
            k++;
        end
        check("basic_cv_latency", k, N + 1);
        check("basic_class_out", class_out, 6);
`else
        check("basic_rv_latency", result_valid, 1);
`endif
        read_chk(6, 5, "basic_bank6");
        read_chk(2, 3, "basic_bank2");
        read_chk(0, 1, "basic_bank0");
        read_chk(3, 0, "basic_bank3");
        ack();
        check("basic_ack_clears", result_valid, 0);

        // Tie
        send(1, 4);
        send(3, 4);
        close_frame(0);
        wait_result();
`ifdef OUTPUT_SPIKE_ARGMAX_EN
        check("tie_class_out", class_out, 1);
`endif
        read_chk(1, 4, "tie_bank1");
        read_chk(3, 4, "tie_bank3");
        ack();

        // Saturation
        send(5, 20);
        check("sat_flag_set", count_saturated, 1);
        close_frame(0);
        wait_result();
        read_chk(5, 15, "sat_bank5");
        drive(0, 0, 0, 0, 1, 0, 0);
        check("sat_flag_cleared", count_saturated, 0);
        ack();

        // Overrun
        send(7, 2);
        close_frame(0);
        wait_result();
        send(7, 3);
        close_frame(0);
        check("overrun_set", frame_overrun, 1);
        read_chk(7, 2, "overrun_bank_kept");
        send(7, 1);
        close_frame(1);
        wait_result();
        read_chk(7, 1, "overrun_ack_loads");
        check("overrun_sticky", frame_overrun, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("overrun_cleared", frame_overrun, 0);
        ack();

        // Boundary packet
        send(4, 1);
        repeat (FT - 1) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 0, 0, 0, 0);
        wait_result();
        read_chk(4, 2, "boundary_bank4");
        ack();
        send(3, 1);
        close_frame(0);
        wait_result();
        read_chk(4, 0, "boundary_next_acc4");
        read_chk(3, 1, "boundary_next_bank3");
        ack();

        // Reset while the scanner (if present) is mid-scan
        send(6, 2);
        send(0, 16);
        close_frame(0);
        read_chk(6, 2, "prereset_bank6");
        idle(1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midscan_reset");
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            idle(1);
            if (class_valid) seen++;
        end
        check("no_cv_after_reset", seen, 0);
        check("rv_after_reset", result_valid, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit t, pv, a, c, re;
            int idx;
            t   = ($urandom_range(0, 2) == 0);
            pv  = $urandom_range(0, 1);
            idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) : $urandom_range(0, N - 1);
            a   = ($urandom_range(0, 5) == 0);
            c   = ($urandom_range(0, 24) == 0);
            re  = $urandom_range(0, 1);
            drive(t, pv, idx, a, c, re, $urandom_range(0, N - 1));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_spike_counter.md
# output_spike_counter

Frame-level spike accumulator directly downstream of the grid output bus. Consumes the bus's local output packets (output-neuron index plus valid strobe), counts spikes per output neuron over a frame of `FRAME_TICKS` ticks, and latches the totals into a result bank for host readout. It optionally performs a sequential argmax to produce a classification index.

## Interface
- `NUM_OUTPUTS`, 256: number of output neurons; index width is `$clog2(NUM_OUTPUTS)`.
- `COUNT_WIDTH`, 8: per-neuron counter width; counters saturate.
- `FRAME_TICKS`, 16: ticks per frame; must be ≥1.
- `clk`  in  1: the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle pulse marking the end of a network tick.
- `packet_in`  in  `$clog2(NUM_OUTPUTS)`: output-neuron index from the output bus.
- `packet_in_valid`  in  1: `packet_in` is valid this cycle.
- `result_ack`  in  1: host has consumed the result bank; clears `result_valid`.
- `clear_errors`  in  1: clears the sticky error flags.
- `rd_en`  in  1: read request for the result bank.
- `rd_addr`  in  `$clog2(NUM_OUTPUTS)`: result bank index to read.
- `rd_data`  out  `COUNT_WIDTH`: registered read data.
- `rd_valid`  out  1: `rd_data` is valid; asserts one cycle after `rd_en`.
- `result_valid`  out  1: level signal; the result bank holds an unacknowledged frame.
- `class_out`  out  `$clog2(NUM_OUTPUTS)`: argmax index of the last frame.
- `class_valid`  out  1: one-cycle pulse when `class_out` updates.
- `frame_overrun`  out  1: sticky; a frame was dropped.
- `count_saturated`  out  1: sticky; a counter hit its maximum.

## Operation
- **Accumulation.** An accumulation counter array `acc[NUM_OUTPUTS]` increments `acc[packet_in]` on each `packet_in_valid`. The counter saturates at `2^COUNT_WIDTH-1`. An increment attempted at saturation sets `count_saturated`.
- **Frame counting.** `tick_cnt` counts 0..`FRAME_TICKS-1`. A `tick` with `tick_cnt==FRAME_TICKS-1` is the frame end: `tick_cnt` wraps to 0. Any other `tick` increments `tick_cnt`.
- **Frame end, bank free.** The bank is free when `result_valid==0`, or when `result_ack` is high in the same cycle, and the FSM is in IDLE. In that case `bank <= acc`, including any valid packet in the same cycle, counted with saturation.
- **Frame end, bank busy.** The bank is left unchanged and `frame_overrun` is set.
- **Array clear.** `acc` clears to 0 at every frame end, whether or not the bank loads.
- **Packet at frame end.** A packet arriving in the frame-end cycle belongs to the closing frame.
- **Argmax FSM** (`OUTPUT_SPIKE_ARGMAX_EN` defined):
  - States: IDLE → SCAN on bank load.
  - SCAN visits index 0..`NUM_OUTPUTS-1`, one per cycle, keeping `best_val` and `best_idx`. It replaces the current best only on strictly greater, so ties resolve to the lowest index.
  - After the last index the FSM goes to DONE. DONE drives `class_out=best_idx`, pulses `class_valid`, sets `result_valid`, and returns to IDLE.
  - A frame end during SCAN or DONE is an overrun.
- **Acknowledge.** `result_ack` with `result_valid==1` clears `result_valid`. An ack with `result_valid==0` is ignored.
- **Readout.** Reads are allowed at any time. While `result_valid==0` the bank contents are undefined for the host.
- **Error clear.** `clear_errors` clears both sticky flags. A set event in the same cycle wins.

## Timing
- **Reset values.** All outputs are 0 on reset, including `rd_data`, `class_out`, both flags and `result_valid`. All counters, `acc`, the bank, `tick_cnt` and the FSM (IDLE) also reset. Reset is asynchronous and aborts a SCAN in progress.
- **Packet latency.** A packet in cycle C is visible in `acc` at C+1.
- **Frame end at cycle T, with argmax.** The bank loads at the T/T+1 edge and SCAN runs for cycles T+1..T+NUM_OUTPUTS. DONE is at T+NUM_OUTPUTS+1: `class_valid` pulses and `result_valid` rises at that cycle.
- **Frame end at cycle T, without argmax.** `result_valid` rises at T+1.
- **Read latency.** `rd_en` at cycle C gives `rd_data`/`rd_valid` at C+1, one read per cycle, fully pipelined.

## Configuration
- Macro: `OUTPUT_SPIKE_ARGMAX_EN`.
- **Defined.** The SCAN/DONE FSM and `argmax_scanner` are instantiated, and `class_out`/`class_valid` are live.
- **Undefined.** There is no FSM. `result_valid` sets the cycle after the bank load, `class_out` and `class_valid` are tied to 0, and an overrun occurs only while `result_valid` is held.

## Structure
- **Package `snn_output_pkg`.**
  - FSM state enum (IDLE, SCAN, DONE).
  - Saturation helper constant `COUNT_MAX = 2^COUNT_WIDTH-1`.
  - Index-width localparam derivation.
- **Sub-module `argmax_scanner`.** It owns the index counter, `best_val`/`best_idx` and the done pulse, and reads the bank through a mux port. The top level holds `acc`, the bank, the tick counter, the read port and the flags.

## Test plan
- **Basic frame.** `FRAME_TICKS=4`, NUM_OUTPUTS=8. Send 3 packets to idx 2, 5 to idx 6 and 1 to idx 0, then 4 ticks → `bank[6]=5`, `bank[2]=3`, `class_out=6`. `class_valid` pulses 9 cycles after the 4th tick.
- **Tie.** 4 spikes to idx 1 and 4 to idx 3 → `class_out=1`.
- **Saturation.** COUNT_WIDTH=4, send 20 packets to idx 5 → `bank[5]=15`, `count_saturated=1`. `clear_errors` → 0.
- **Overrun.** Do not ack and complete a second frame → `frame_overrun=1` and the bank still holds frame 1. Then ack in the same cycle as the third frame end → the bank loads frame 3.
- **Boundary packet.** A packet to idx 4 in the frame-end tick cycle → counted in the closing frame's `bank[4]`, and the next frame's `acc[4]` starts at 0.
- **Reset mid-SCAN.** Deassert `reset_n` during SCAN → all outputs 0 immediately, and no `class_valid` pulse follows.
